// File: rtl/segmentos_mux_n_if.sv
// rtl/segmentos_mux_n_if.sv - datapath-side and pin-side signals of the digit scanner
interface segmentos_mux_n_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic                    load;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blank_in;
    logic                    lz_en;
    logic [6:0]              seg_out;
    logic                    dp_out;
    logic [NUM_DIGITS-1:0]   an_out;
    logic                    frame_done;

    modport master (
        output digits_in, load, dp_in, blank_in, lz_en,
        input  seg_out, dp_out, an_out, frame_done
    );

    modport slave (
        input  digits_in, load, dp_in, blank_in, lz_en,
        output seg_out, dp_out, an_out, frame_done
    );
endinterface

// File: rtl/segmentos_mux_n.sv
// rtl/segmentos_mux_n.sv - time-multiplexed common-anode 7-segment scanner
module segmentos_mux_n #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16,
    parameter int HEX_MODE     = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    segmentos_mux_n_if.slave bus
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [CW-1:0]           cnt, cnt_next;
    logic [IW-1:0]           idx, idx_next;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic                    first_slot;
    logic                    cnt_wrap, idx_last, upper_zero, dark;
    logic [3:0]              nib;
    logic [6:0]              seg_dec;
    logic [NUM_DIGITS-1:0]   an_next;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'h0: decode = 7'h40;
            4'h1: decode = 7'h79;
            4'h2: decode = 7'h24;
            4'h3: decode = 7'h30;
            4'h4: decode = 7'h19;
            4'h5: decode = 7'h12;
            4'h6: decode = 7'h02;
            4'h7: decode = 7'h78;
            4'h8: decode = 7'h00;
            4'h9: decode = 7'h18;
            4'hA: decode = (HEX_MODE != 0) ? 7'h08 : 7'h7E;
            4'hB: decode = (HEX_MODE != 0) ? 7'h03 : 7'h7E;
            4'hC: decode = (HEX_MODE != 0) ? 7'h46 : 7'h7E;
            4'hD: decode = (HEX_MODE != 0) ? 7'h21 : 7'h7E;
            4'hE: decode = (HEX_MODE != 0) ? 7'h06 : 7'h7E;
            default: decode = (HEX_MODE != 0) ? 7'h0E : 7'h7E;
        endcase
    endfunction

    always_comb begin
        cnt_wrap = (cnt == CW'(REFRESH_DIV - 1));
        cnt_next = cnt_wrap ? '0 : cnt + 1'b1;
        idx_last = (idx == IW'(NUM_DIGITS - 1));
        idx_next = idx;
        if (cnt_wrap) idx_next = idx_last ? '0 : idx + 1'b1;

        nib = shadow[{idx_next, 2'b00} +: 4];
        seg_dec = decode(nib);

        // Suppress only when this digit and every more-significant digit is zero.
        upper_zero = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (i >= int'(idx_next) && shadow[i*4 +: 4] != 4'd0) upper_zero = 1'b0;
        end
        dark = bus.blank_in[idx_next] | (bus.lz_en & (idx_next != '0) & upper_zero);

        an_next = '1;
        if (cnt_next >= CW'(BLANK_CYCLES)) an_next[idx_next] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt            <= '0;
            idx            <= '0;
            shadow         <= '0;
            first_slot     <= 1'b1;
            bus.seg_out    <= 7'h7F;
            bus.dp_out     <= 1'b1;
            bus.an_out     <= '1;
            bus.frame_done <= 1'b0;
        end else begin
            cnt            <= cnt_next;
            idx            <= idx_next;
            first_slot     <= 1'b0;
            bus.an_out     <= an_next;
            bus.frame_done <= cnt_wrap & idx_last;
            if (bus.load) shadow <= bus.digits_in;
            // The slot after reset starts at cnt=0 already, so it latches on its first live edge.
            if (cnt_wrap || first_slot) begin
                bus.seg_out <= dark ? 7'h7F : seg_dec;
                bus.dp_out  <= dark ? 1'b1 : ~bus.dp_in[idx_next];
            end
        end
    end
endmodule
